uprj_slot_ctrl: RTL and testbench
=================================

// Module: uprj_slot_ctrl
// PURPOSE
//  Safe-switch controller for the user-project slot mux behind the fabric's top UIO edge.
//  Filters the fabric's project-select request and sequences every change as drain -> switch -> settle.
//  Drives per-project resets, clock enables and the gated 128-bit return bus into UIO_TOP_UIN.
//  Holds all projects in reset until fabric configuration is done.
// PARAMETERS
//  NUM_PRJ      4    number of project slots; legal values 2..2**SEL_W
//  SEL_W        2    width of the select request
//  HPC_W        128  return-bus width per slot
//  PRE_RST_CYC  4    DRAIN cycles: old project held in reset with its clock still enabled
//  POST_RST_CYC 8    SETTLE cycles: new project clocked while held in reset; minimum 1
// PORTS
//  clk          in   1               user clock; the only clock
//  resetb       in   1               asynchronous active-low reset
//  fabric_done  in   1               fabric configured; level input
//  req_sel      in   SEL_W           requested slot, from fabric UOUT
//  req_reset    in   1               fabric-driven reset for the running project, active high
//  hpc_in       in   NUM_PRJ*HPC_W   concatenated project outputs; slot k at [k*HPC_W +: HPC_W]
//  hpc_out      out  HPC_W           selected project's output; zero unless in RUN
//  prj_sel_o    out  SEL_W           currently committed slot
//  prj_reset_o  out  NUM_PRJ         per-project reset, active high
//  prj_clk_en_o out  NUM_PRJ         per-project clock enable
//  busy_o       out  1               high in DRAIN, SWITCH and SETTLE
//  sel_err_o    out  1               one-cycle pulse per new illegal request (req_sel >= NUM_PRJ)
//  switch_cnt_o out  8               committed switches; saturates at 255
// BEHAVIOUR
//  Reset values: prj_sel_o=0, prj_reset_o=all 1, prj_clk_en_o=0, busy_o=0, sel_err_o=0,
//   switch_cnt_o=0, hpc_out=0. State resets to IDLE.
//  Filter: the filtered select f_sel updates only when req_sel matches its previous-cycle value.
//   A request is therefore seen after 2 stable cycles.
//  States (registered; all outputs are decoded from registered state and prj_sel_o):
//   IDLE: all resets 1, all clock enables 0.
//    On fabric_done=1, go to SETTLE targeting f_sel, or slot 0 if f_sel is illegal.
//   RUN: clk_en[sel]=1, reset[sel]=req_reset (combinational pass-through).
//    All other slots: reset 1, clk_en 0. hpc_out = hpc_in slice[sel].
//    If f_sel is legal and f_sel != sel: latch target, go to DRAIN.
//   DRAIN (PRE_RST_CYC cycles): reset[old]=1, clk_en[old]=1, hpc_out=0.
//   SWITCH (1 cycle): all clock enables 0, all resets 1. prj_sel_o <= target;
//    switch_cnt_o increments, saturating.
//   SETTLE (POST_RST_CYC cycles): clk_en[new]=1, reset[new]=1, hpc_out=0, then go to RUN.
//  Latency: RUN to first RUN cycle on the new slot is PRE_RST_CYC + 1 + POST_RST_CYC cycles.
//  Request changes during DRAIN, SWITCH or SETTLE are ignored; the latched target completes.
//   A pending difference is re-evaluated on the first RUN cycle.
//  Illegal request (f_sel >= NUM_PRJ): no switch. sel_err_o pulses once when the illegal f_sel first appears.
//  fabric_done falling in any state: the next state is IDLE; prj_sel_o is retained.
//   busy_o drops and the count is unchanged.
//  req_reset has no effect outside RUN.
//  Phase counter: $clog2(max(PRE_RST_CYC, POST_RST_CYC) + 1) bits. It reloads on every state entry.
//  Asynchronous reset mid-sequence: returns immediately to the reset values above.
// STRUCTURE
//  Shared package: state encoding localparams (IDLE, RUN, DRAIN, SWITCH, SETTLE).
//   Also the 13-bit GPIO default constants used by the slot user IO.
//  One sub-module, uprj_sel_filter: the 2-stage stability filter plus illegal-request pulse.
//  The FSM, phase counter and output mux stay in this module.
// TESTING
//  1. Reset, fabric_done=1, req_sel=2 stable -> RUN after 8 SETTLE cycles; prj_sel_o=2;
//     clk_en=4'b0100; reset=4'b1011; switch_cnt_o=1.
//  2. RUN on slot 0, req_sel 0->3 -> busy_o high for exactly 13 cycles; hpc_out=0 throughout;
//     prj_sel_o=3 on cycle 5; switch_cnt_o increments by 1.
//  3. req_sel toggles 1/2 every cycle -> no switch, busy_o stays 0.
//  4. NUM_PRJ=3, req_sel=3 -> sel_err_o single pulse; slot unchanged.
//  5. fabric_done dropped mid-SETTLE -> next cycle all resets 1, clk_en 0, busy_o 0.
//  6. req_sel changed during DRAIN -> the latched target completes;
//     a second switch starts on the first RUN cycle.

Source files
------------

// File: rtl/uprj_slot_ctrl_pkg.sv
// Shared definitions for the user-project slot controller.
//   slot_state_e : controller state encoding
//   GPIO_MODE_*  : 13-bit default pad configurations used by the slot user IO
//   sat_inc8     : saturating 8-bit increment for the switch counter
package uprj_slot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SWITCH = 3'd3,
    ST_SETTLE = 3'd4
  } slot_state_e;

  localparam logic [12:0] GPIO_MODE_MGMT_STD_INPUT_NOPULL  = 13'h0403;
  localparam logic [12:0] GPIO_MODE_USER_STD_INPUT_NOPULL  = 13'h0402;
  localparam logic [12:0] GPIO_MODE_USER_STD_OUTPUT        = 13'h1808;
  localparam logic [12:0] GPIO_MODE_USER_STD_BIDIRECTIONAL = 13'h1800;
  localparam logic [12:0] GPIO_MODE_USER_STD_ANALOG        = 13'h000a;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uprj_slot_ctrl_sel_filter.sv
// Two-stage stability filter for the fabric's project-select request.
// The filtered select only follows req_sel_i when it held the same value on
// two consecutive clocks; a one-cycle sel_err_o pulse marks each new illegal
// filtered value.
//   clk, resetb : clock, async active-low reset
//   req_sel_i   : raw select request from the fabric
//   f_sel_o     : filtered select (registered)
//   f_legal_o   : f_sel_o < NUM_PRJ
//   sel_err_o   : registered pulse when f_sel first takes a new illegal value
module uprj_sel_filter
  import uprj_slot_ctrl_pkg::*;
#(
  parameter int NUM_PRJ = 4,
  parameter int SEL_W   = 2
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [SEL_W-1:0] req_sel_i,
  output logic [SEL_W-1:0] f_sel_o,
  output logic             f_legal_o,
  output logic             sel_err_o
);

  localparam logic [SEL_W:0] NUM_PRJ_L = (SEL_W+1)'(NUM_PRJ);

  logic [SEL_W-1:0] req_q;
  logic [SEL_W-1:0] f_sel_q, f_sel_d;
  logic             err_q, err_d;

  always_comb begin
    f_sel_d = (req_sel_i == req_q) ? req_sel_i : f_sel_q;
    // Pulse only on the edge where f_sel changes to an illegal value.
    err_d   = ({1'b0, f_sel_d} >= NUM_PRJ_L) && (f_sel_d != f_sel_q);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      req_q   <= '0;
      f_sel_q <= '0;
      err_q   <= 1'b0;
    end else begin
      req_q   <= req_sel_i;
      f_sel_q <= f_sel_d;
      err_q   <= err_d;
    end
  end

  assign f_sel_o   = f_sel_q;
  assign f_legal_o = ({1'b0, f_sel_q} < NUM_PRJ_L);
  assign sel_err_o = err_q;

endmodule

// File: rtl/uprj_slot_ctrl.sv
// Safe-switch controller for the user-project slot mux behind the top UIO edge.
// Every change of the filtered select is sequenced drain -> switch -> settle,
// and all projects are held in reset until the fabric is configured.
//   clk, resetb    : clock, async active-low reset
//   fabric_done    : fabric configured (level)
//   req_sel        : requested slot from the fabric
//   req_reset      : fabric reset for the running project (active high)
//   hpc_in         : concatenated project outputs, slot k at [k*HPC_W +: HPC_W]
//   hpc_out        : selected project's output, zero unless running
//   prj_sel_o      : committed slot
//   prj_reset_o    : per-project reset (active high)
//   prj_clk_en_o   : per-project clock enable
//   busy_o         : switch sequence in progress
//   sel_err_o      : pulse per new illegal request
//   switch_cnt_o   : committed switches, saturating
//
// state  | meaning
// IDLE   | fabric not done: every project in reset, all clocks off
// RUN    | committed slot clocked, reset follows req_reset, return bus live
// DRAIN  | old slot held in reset with its clock still running
// SWITCH | one cycle with every clock off; new slot committed on entry
// SETTLE | new slot clocked while held in reset
module uprj_slot_ctrl
  import uprj_slot_ctrl_pkg::*;
#(
  parameter int NUM_PRJ      = 4,
  parameter int SEL_W        = 2,
  parameter int HPC_W        = 128,
  parameter int PRE_RST_CYC  = 4,
  parameter int POST_RST_CYC = 8
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     fabric_done,
  input  logic [SEL_W-1:0]         req_sel,
  input  logic                     req_reset,
  input  logic [NUM_PRJ*HPC_W-1:0] hpc_in,
  output logic [HPC_W-1:0]         hpc_out,
  output logic [SEL_W-1:0]         prj_sel_o,
  output logic [NUM_PRJ-1:0]       prj_reset_o,
  output logic [NUM_PRJ-1:0]       prj_clk_en_o,
  output logic                     busy_o,
  output logic                     sel_err_o,
  output logic [7:0]               switch_cnt_o
);

  localparam int MAX_CYC = (PRE_RST_CYC > POST_RST_CYC) ? PRE_RST_CYC : POST_RST_CYC;
  localparam int PH_W    = $clog2(MAX_CYC + 1);
  localparam logic [PH_W-1:0] PRE_LOAD  = PH_W'((PRE_RST_CYC > 0) ? PRE_RST_CYC - 1 : 0);
  localparam logic [PH_W-1:0] POST_LOAD = PH_W'((POST_RST_CYC > 0) ? POST_RST_CYC - 1 : 0);

  slot_state_e      state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0] f_sel;
  logic             f_legal;

  uprj_sel_filter #(
    .NUM_PRJ (NUM_PRJ),
    .SEL_W   (SEL_W)
  ) u_filter (
    .clk       (clk),
    .resetb    (resetb),
    .req_sel_i (req_sel),
    .f_sel_o   (f_sel),
    .f_legal_o (f_legal),
    .sel_err_o (sel_err_o)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= ST_IDLE;
      ph_q     <= '0;
      target_q <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
    end
  end

  // The slot commit and the counter bump happen on the transition into
  // SWITCH (or into SETTLE from IDLE), so prj_sel_o already shows the new
  // slot while every clock is off.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    target_d = target_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    if (!fabric_done) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          target_d = f_legal ? f_sel : '0;
          sel_d    = target_d;
          cnt_d    = sat_inc8(cnt_q);
          ph_d     = POST_LOAD;
          state_d  = ST_SETTLE;
        end
        ST_RUN: begin
          if (f_legal && (f_sel != sel_q)) begin
            target_d = f_sel;
            if (PRE_RST_CYC > 0) begin
              ph_d    = PRE_LOAD;
              state_d = ST_DRAIN;
            end else begin
              sel_d   = f_sel;
              cnt_d   = sat_inc8(cnt_q);
              state_d = ST_SWITCH;
            end
          end
        end
        ST_DRAIN: begin
          if (ph_q == '0) begin
            sel_d   = target_q;
            cnt_d   = sat_inc8(cnt_q);
            state_d = ST_SWITCH;
          end else begin
            ph_d = ph_q - PH_W'(1);
          end
        end
        ST_SWITCH: begin
          ph_d    = POST_LOAD;
          state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (ph_q == '0) begin
            state_d = ST_RUN;
          end else begin
            ph_d = ph_q - PH_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    prj_reset_o  = '1;
    prj_clk_en_o = '0;
    hpc_out      = '0;
    for (int k = 0; k < NUM_PRJ; k++) begin
      if (sel_q == SEL_W'(k)) begin
        case (state_q)
          ST_RUN: begin
            prj_clk_en_o[k] = 1'b1;
            prj_reset_o[k]  = req_reset;
            hpc_out         = hpc_in[k*HPC_W +: HPC_W];
          end
          ST_DRAIN, ST_SETTLE: prj_clk_en_o[k] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign busy_o       = (state_q == ST_DRAIN) || (state_q == ST_SWITCH) || (state_q == ST_SETTLE);
  assign prj_sel_o    = sel_q;
  assign switch_cnt_o = cnt_q;

endmodule

// File: tb/tb_uprj_slot_ctrl.sv
module tb_uprj_slot_ctrl;

  localparam int HPC_W = 128;
  localparam int PRE   = 4;
  localparam int POST  = 8;

  logic             clk = 1'b0;
  logic             resetb;
  logic             fabric_done;
  logic [1:0]       req_sel;
  logic             req_reset;
  logic [4*HPC_W-1:0] hpc_in;

  logic [HPC_W-1:0] hpc4, hpc3;
  logic [1:0]       sel4, sel3;
  logic [3:0]       rst4, en4;
  logic [2:0]       rst3, en3;
  logic             busy4, busy3, err4, err3;
  logic [7:0]       cnt4, cnt3;

  always #5 clk = ~clk;

  uprj_slot_ctrl #(.NUM_PRJ(4), .SEL_W(2), .HPC_W(HPC_W), .PRE_RST_CYC(PRE), .POST_RST_CYC(POST)) dut4 (
    .clk(clk), .resetb(resetb), .fabric_done(fabric_done), .req_sel(req_sel),
    .req_reset(req_reset), .hpc_in(hpc_in), .hpc_out(hpc4), .prj_sel_o(sel4),
    .prj_reset_o(rst4), .prj_clk_en_o(en4), .busy_o(busy4), .sel_err_o(err4),
    .switch_cnt_o(cnt4));

  uprj_slot_ctrl #(.NUM_PRJ(3), .SEL_W(2), .HPC_W(HPC_W), .PRE_RST_CYC(PRE), .POST_RST_CYC(POST)) dut3 (
    .clk(clk), .resetb(resetb), .fabric_done(fabric_done), .req_sel(req_sel),
    .req_reset(req_reset), .hpc_in(hpc_in[3*HPC_W-1:0]), .hpc_out(hpc3), .prj_sel_o(sel3),
    .prj_reset_o(rst3), .prj_clk_en_o(en3), .busy_o(busy3), .sel_err_o(err3),
    .switch_cnt_o(cnt3));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected sequence to complete", name);
  endtask

  // Reference model: a switch is an episode with an age counted from its
  // first busy cycle; the phase is read off the age by plain arithmetic.
  bit m_idle[2], m_busy[2], m_from_idle[2], m_err[2];
  int m_age[2], m_sel[2], m_target[2], m_cnt[2], m_fsel[2], m_prev[2];

  function automatic int np(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_idle[i] = 1'b1; m_busy[i] = 1'b0; m_from_idle[i] = 1'b0; m_err[i] = 1'b0;
      m_age[i] = 0; m_sel[i] = 0; m_target[i] = 0; m_cnt[i] = 0; m_fsel[i] = 0; m_prev[i] = 0;
    end
  endtask

  task automatic model_update();
    int  nf;
    bit  legal;
    int  rs;
    rs = int'(req_sel);
    for (int i = 0; i < 2; i++) begin
      nf    = (rs == m_prev[i]) ? rs : m_fsel[i];
      legal = (m_fsel[i] < np(i));
      if (!fabric_done) begin
        m_idle[i] = 1'b1;
        m_busy[i] = 1'b0;
      end else if (m_idle[i]) begin
        m_idle[i] = 1'b0; m_busy[i] = 1'b1; m_from_idle[i] = 1'b1; m_age[i] = 0;
        m_sel[i] = legal ? m_fsel[i] : 0;
        m_cnt[i] = sat(m_cnt[i]);
      end else if (m_busy[i]) begin
        m_age[i]++;
        if (!m_from_idle[i] && m_age[i] == PRE) begin
          m_sel[i] = m_target[i];
          m_cnt[i] = sat(m_cnt[i]);
        end
        if (m_age[i] == (m_from_idle[i] ? POST : PRE + 1 + POST)) m_busy[i] = 1'b0;
      end else if (legal && m_fsel[i] != m_sel[i]) begin
        m_busy[i] = 1'b1; m_from_idle[i] = 1'b0; m_age[i] = 0; m_target[i] = m_fsel[i];
      end
      m_err[i]  = (nf >= np(i)) && (nf != m_fsel[i]);
      m_fsel[i] = nf;
      m_prev[i] = rs;
    end
  endtask

  task automatic model_check();
    logic [3:0]       e_rst, e_en, a_rst, a_en;
    logic [HPC_W-1:0] e_hpc, a_hpc;
    logic             e_busy;
    int               s;
    string            p;
    for (int i = 0; i < 2; i++) begin
      s      = m_sel[i];
      e_rst  = (i == 0) ? 4'hF : 4'h7;
      e_en   = 4'h0;
      e_hpc  = '0;
      e_busy = 1'b0;
      if (!m_idle[i]) begin
        if (!m_busy[i]) begin
          e_en     = 4'(1 << s);
          e_rst[s] = req_reset;
          e_hpc    = hpc_in[s*HPC_W +: HPC_W];
        end else begin
          e_busy = 1'b1;
          if (m_from_idle[i] || m_age[i] != PRE) e_en = 4'(1 << s);
        end
      end
      p     = (i == 0) ? "dut4" : "dut3";
      a_rst = (i == 0) ? rst4 : {1'b0, rst3};
      a_en  = (i == 0) ? en4 : {1'b0, en3};
      a_hpc = (i == 0) ? hpc4 : hpc3;
      check({p, ".sel"},   128'((i == 0) ? sel4 : sel3), 128'(s));
      check({p, ".reset"}, 128'(a_rst), 128'(e_rst));
      check({p, ".clk_en"}, 128'(a_en), 128'(e_en));
      check({p, ".busy"},  128'((i == 0) ? busy4 : busy3), 128'(e_busy));
      check({p, ".err"},   128'((i == 0) ? err4 : err3), 128'(m_err[i]));
      check({p, ".count"}, 128'((i == 0) ? cnt4 : cnt3), 128'(m_cnt[i]));
      check({p, ".hpc"},   a_hpc, e_hpc);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (resetb) model_update();
    else model_reset();
    #4;
    model_check();
  endtask

  // Runs until a busy period of dut4 has started and ended; nb = busy cycles.
  task automatic wait_seq(input string name, input int maxc, output int nb);
    bit done;
    nb   = 0;
    done = 1'b0;
    for (int c = 0; c < maxc && !done; c++) begin
      cyc();
      if (busy4) nb++;
      else if (nb > 0) done = 1'b1;
    end
    if (!done) timeout(name);
  endtask

  typedef struct {
    bit         rr;
    logic [31:0] word;
    logic [3:0]  exp_rst;
    logic [31:0] exp_word;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, ne, s3bad, b3, hbad, f3, ph, b1, gap, b2, gsel;
    logic [31:0] w;

    tbl[0] = '{1'b0, 32'hA5A5_0000, 4'b1011, 32'hA5A5_0002};
    tbl[1] = '{1'b1, 32'h1234_5670, 4'b1111, 32'h1234_5672};
    tbl[2] = '{1'b0, 32'hFFFF_FFF0, 4'b1011, 32'hFFFF_FFF2};
    tbl[3] = '{1'b1, 32'h0000_0000, 4'b1111, 32'h0000_0002};
    tbl[4] = '{1'b1, 32'hDEAD_BEE0, 4'b1111, 32'hDEAD_BEE2};
    tbl[5] = '{1'b0, 32'h0F0F_0F00, 4'b1011, 32'h0F0F_0F02};

    resetb = 1'b1; fabric_done = 1'b0; req_sel = 2'd2; req_reset = 1'b0;
    for (int k = 0; k < 16; k++) hpc_in[k*32 +: 32] = $urandom();
    model_reset();
    #1 resetb = 1'b0;
    #1;
    check("rst.sel", 128'(sel4), 128'(0));
    check("rst.reset", 128'(rst4), 128'(4'hF));
    check("rst.clk_en", 128'(en4), 128'(0));
    check("rst.busy", 128'(busy4), 128'(0));
    check("rst.err", 128'(err4), 128'(0));
    check("rst.count", 128'(cnt4), 128'(0));
    check("rst.hpc", hpc4, 128'(0));
    model_check();
    cyc(); cyc();
    resetb = 1'b1;
    cyc(); cyc(); cyc();

    // Test 1: first bring-up onto slot 2
    fabric_done = 1'b1;
    wait_seq("t1.seq", 40, nb);
    check("t1.settle_cycles", 128'(nb), 128'(POST));
    check("t1.sel", 128'(sel4), 128'(2));
    check("t1.clk_en", 128'(en4), 128'(4'b0100));
    check("t1.reset", 128'(rst4), 128'(4'b1011));
    check("t1.count", 128'(cnt4), 128'(1));

    // Table: RUN on slot 2, reset pass-through and return-bus mux
    for (int i = 0; i < 6; i++) begin
      req_reset = tbl[i].rr;
      for (int k = 0; k < 4; k++) begin
        w = tbl[i].word + 32'(k);
        hpc_in[k*HPC_W +: HPC_W] = {4{w}};
      end
      cyc();
      check("tbl.hpc", hpc4, {4{tbl[i].exp_word}});
      check("tbl.reset", 128'(rst4), 128'(tbl[i].exp_rst));
      check("tbl.clk_en", 128'(en4), 128'(4'b0100));
    end
    req_reset = 1'b0;

    // Test 3: request toggling every cycle never passes the filter
    for (int c = 0; c < 20; c++) begin
      req_sel = (c % 2 == 1) ? 2'd2 : 2'd1;
      cyc();
      check("t3.busy", 128'(busy4), 128'(0));
    end
    check("t3.sel", 128'(sel4), 128'(2));
    check("t3.count", 128'(cnt4), 128'(1));

    req_sel = 2'd0;
    wait_seq("t2.pre", 40, nb);
    check("t2.pre_sel", 128'(sel4), 128'(0));

    // Test 2 (dut4: 0 -> 3) and Test 4 (dut3: 3 illegal)
    req_sel = 2'd3;
    nb = 0; ne = 0; s3bad = 0; b3 = 0; hbad = 0; f3 = 0;
    begin
      bit done;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        cyc();
        if (err3) ne++;
        if (sel3 != 2'd0) s3bad++;
        if (busy3) b3++;
        if (busy4) begin
          nb++;
          if (hpc4 != '0) hbad++;
          if (sel4 == 2'd3 && f3 == 0) f3 = nb;
        end else if (nb > 0) done = 1'b1;
      end
      if (!done) timeout("t2.seq");
    end
    for (int c = 0; c < 3; c++) begin
      cyc();
      if (err3) ne++;
    end
    check("t2.busy_cycles", 128'(nb), 128'(13));
    check("t2.hpc_nonzero", 128'(hbad), 128'(0));
    check("t2.sel_cycle", 128'(f3), 128'(5));
    check("t2.sel", 128'(sel4), 128'(3));
    check("t2.count", 128'(cnt4), 128'(3));
    check("t4.err_pulses", 128'(ne), 128'(1));
    check("t4.sel_changes", 128'(s3bad), 128'(0));
    check("t4.busy_cycles", 128'(b3), 128'(0));

    // Test 6: request changed mid-DRAIN
    req_sel = 2'd1;
    ph = 0; b1 = 0; gap = 0; b2 = 0; gsel = -1;
    for (int c = 0; c < 80 && ph < 4; c++) begin
      cyc();
      case (ph)
        0: if (busy4) begin ph = 1; b1 = 1; end
        1: if (busy4) b1++; else begin ph = 2; gap = 1; gsel = int'(sel4); end
        2: if (busy4) begin ph = 3; b2 = 1; end else gap++;
        3: if (busy4) b2++; else ph = 4;
        default: ;
      endcase
      if (ph == 1 && b1 == 2) req_sel = 2'd2;
    end
    if (ph != 4) timeout("t6.seq");
    check("t6.first_busy", 128'(b1), 128'(13));
    check("t6.gap", 128'(gap), 128'(1));
    check("t6.gap_sel", 128'(gsel), 128'(1));
    check("t6.second_busy", 128'(b2), 128'(13));
    check("t6.sel", 128'(sel4), 128'(2));
    check("t6.count", 128'(cnt4), 128'(5));

    // Test 5: fabric_done dropped in the third SETTLE cycle
    req_sel = 2'd0;
    nb = 0;
    for (int c = 0; c < 40 && nb < PRE + 1 + 3; c++) begin
      cyc();
      if (busy4) nb++;
    end
    if (nb < PRE + 1 + 3) timeout("t5.seq");
    fabric_done = 1'b0;
    cyc();
    check("t5.reset", 128'(rst4), 128'(4'hF));
    check("t5.clk_en", 128'(en4), 128'(0));
    check("t5.busy", 128'(busy4), 128'(0));
    check("t5.sel", 128'(sel4), 128'(0));
    check("t5.count", 128'(cnt4), 128'(6));
    fabric_done = 1'b1;
    wait_seq("t5.resume", 40, nb);
    check("t5.resume_cycles", 128'(nb), 128'(POST));
    check("t5.resume_count", 128'(cnt4), 128'(7));

    // Asynchronous reset in the middle of DRAIN
    req_sel = 2'd2;
    nb = 0;
    for (int c = 0; c < 40 && nb < 2; c++) begin
      cyc();
      if (busy4) nb++;
    end
    if (nb < 2) timeout("ar.seq");
    #2 resetb = 1'b0;
    model_reset();
    #1;
    check("ar.sel", 128'(sel4), 128'(0));
    check("ar.reset", 128'(rst4), 128'(4'hF));
    check("ar.clk_en", 128'(en4), 128'(0));
    check("ar.busy", 128'(busy4), 128'(0));
    check("ar.count", 128'(cnt4), 128'(0));
    check("ar.hpc", hpc4, 128'(0));
    cyc();
    resetb = 1'b1;

    // Randomised traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) < 2) req_sel = 2'($urandom_range(0, 3));
      if (fabric_done && $urandom_range(0, 199) == 0) fabric_done = 1'b0;
      else if (!fabric_done && $urandom_range(0, 3) == 0) fabric_done = 1'b1;
      req_reset = 1'($urandom_range(0, 1));
      for (int k = 0; k < 16; k++) hpc_in[k*32 +: 32] = $urandom();
      if (c == 1500) resetb = 1'b0;
      if (c == 1502) resetb = 1'b1;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
